ax_branch_cycle_window: RTL
===========================

Name: ax_branch_cycle_window

Overview:
Producer side of the cycle-based approximate-branch decision. Owns the free-running cycle counter, the CSR-programmed threshold and the captured region-begin cycle, and drives the three values consumed by the fetch-stage cycle decider. A small FSM arms a window on a region-begin event, tracks expiry, and counts decided-taken events for software readback. Lives beside the fetch unit and is written through the CSR path.

Parameters:
DATA_WIDTH, 32, width of counter, begin cycle and threshold (DataPath).
TAKEN_CNT_WIDTH, 16, width of the saturating decided-taken counter.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
csrWE  input  1  CSR write strobe
csrAddr  input  2  CSR register select
csrWData  input  DATA_WIDTH  CSR write data
csrRData  output  DATA_WIDTH  CSR read data, combinational from csrAddr
regionBegin  input  1  pulse: approximate region entered (from commit)
regionEnd  input  1  pulse: approximate region left
decidTaken  input  1  pulse: decider forced a taken branch this cycle
cyclecounter  output  DATA_WIDTH  free-running cycle count
begincycle  output  DATA_WIDTH  begin cycle presented to decider
threshold  output  DATA_WIDTH  threshold presented to decider
windowActive  output  1  state is ARMED or EXPIRED
windowExpired  output  1  state is EXPIRED

Behaviour:
- Clock and reset are fixed: single clock clk, synchronous active-high reset rst.
- Reset values: counter 0, thresholdReg 0, enable 0, beginReg 0, thrLatched 0, deadline 0, takenCount 0, overflowSticky 0, state IDLE.
- cyclecounter: increments by 1 every cycle, wraps mod 2^DATA_WIDTH, and is output directly.
- CSR map. Writes take effect on the next edge.
  - 0: thresholdReg, RW.
  - 1: control. Bit0 is enable, RW. Bits[2:1] are state, RO (IDLE=0, ARMED=1, EXPIRED=2). Other bits read 0.
  - 2: beginReg, RO; writes ignored.
  - 3: bit31 overflowSticky, bits[TAKEN_CNT_WIDTH-1:0] takenCount. Any write clears both.
- Outputs by state:
  - IDLE: begincycle = 0, threshold = all-ones. The decider's compare can never be true.
  - ARMED and EXPIRED: begincycle = beginReg, threshold = thrLatched.
- FSM transitions, evaluated in this order:
  - IDLE: regionBegin && enable && !regionEnd → compute sum = cyclecounter + thresholdReg at DATA_WIDTH+1 bits.
    - Carry set: overflowSticky ← 1, stay IDLE.
    - Carry clear: beginReg ← cyclecounter, thrLatched ← thresholdReg, deadline ← sum[DATA_WIDTH-1:0], go to ARMED.
  - ARMED:
    - regionEnd or !enable → IDLE.
    - Else if cyclecounter > deadline (unsigned, current counter value) → EXPIRED.
  - EXPIRED: regionEnd or !enable → IDLE.
  - regionBegin while ARMED or EXPIRED is ignored (no re-arm).
- thresholdReg writes while ARMED or EXPIRED affect only the next arm. thrLatched is stable for the window.
- takenCount increments on decidTaken only in EXPIRED, saturating at all-ones. decidTaken in IDLE or ARMED is ignored.
- A CSR clear and an increment in the same cycle: the clear wins.
- Simultaneous regionBegin and regionEnd in IDLE: stay IDLE.
- Enable cleared by a CSR write: the FSM reaches IDLE on the edge after the write lands.
- windowActive and windowExpired are decoded from registered state only; no combinational inputs.
- Reset mid-window returns everything to reset values on the next edge.

Test Plan:
- Reset, then 5 idle cycles → cyclecounter = 5, begincycle = 0, threshold = 0xFFFFFFFF, csrRData@1 = 0.
- Write thr = 10, write enable = 1, pulse regionBegin at counter = 20 → beginReg = 20, ARMED. windowExpired rises the cycle after counter reaches 31 (first counter > 30). Pulse decidTaken 3× → csrRData@3 = 3.
- Armed with thr = 10, write thr = 50 → threshold output stays 10. Pulse regionEnd then re-arm at counter = 100 → threshold = 50, deadline = 150.
- thr = 0xFFFFFFF0, regionBegin at counter = 0x20 → stays IDLE, csrRData@3 bit31 = 1. Write addr 3 → reads 0.
- regionBegin with enable = 0 → stays IDLE. Armed, then write enable = 0 → IDLE after one edge, outputs revert to 0 / all-ones.
- EXPIRED, decidTaken held high for 70000 cycles → takenCount saturates at 0xFFFF. Assert rst in the same window → all outputs back to reset values next cycle.

Source files
------------

// File: rtl/ax_branch_cycle_window.sv
// Cycle-window producer for the fetch-stage approximate-branch decider.
// Owns the cycle counter, threshold CSRs, arm/expire FSM and taken counter.
module ax_branch_cycle_window #(
    parameter int DATA_WIDTH      = 32,
    parameter int TAKEN_CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csrWE,
    input  logic [1:0]            csrAddr,
    input  logic [DATA_WIDTH-1:0] csrWData,
    output logic [DATA_WIDTH-1:0] csrRData,
    input  logic                  regionBegin,
    input  logic                  regionEnd,
    input  logic                  decidTaken,
    output logic [DATA_WIDTH-1:0] cyclecounter,
    output logic [DATA_WIDTH-1:0] begincycle,
    output logic [DATA_WIDTH-1:0] threshold,
    output logic                  windowActive,
    output logic                  windowExpired
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_WIDTH-1:0]      counter;
    logic [DATA_WIDTH-1:0]      threshold_reg;
    logic                       enable;
    logic [DATA_WIDTH-1:0]      begin_reg;
    logic [DATA_WIDTH-1:0]      thr_latched;
    logic [DATA_WIDTH-1:0]      deadline;
    logic [TAKEN_CNT_WIDTH-1:0] taken_count;
    logic                       overflow_sticky;

    logic [DATA_WIDTH:0] sum;
    logic                arm;
    logic                ovf_set;
    logic                wr_thr;
    logic                wr_ctrl;
    logic                wr_clr;
    logic                take_inc;

    assign sum = {1'b0, counter} + {1'b0, threshold_reg};

    assign wr_thr  = csrWE && (csrAddr == 2'd0);
    assign wr_ctrl = csrWE && (csrAddr == 2'd1);
    assign wr_clr  = csrWE && (csrAddr == 2'd3);

    assign take_inc = (state_q == EXPIRED) && decidTaken
                      && (taken_count != {TAKEN_CNT_WIDTH{1'b1}});

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) counter <= '0;
        else     counter <= counter + DATA_WIDTH'(1);
    end

    // Software-visible configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            threshold_reg <= '0;
            enable        <= 1'b0;
        end else begin
            if (wr_thr)  threshold_reg <= csrWData;
            if (wr_ctrl) enable        <= csrWData[0];
        end
    end

    // Window state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode; an arm whose deadline would wrap is refused.
    always_comb begin
        state_d = state_q;
        arm     = 1'b0;
        ovf_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (regionBegin && enable && !regionEnd) begin
                    if (sum[DATA_WIDTH]) begin
                        ovf_set = 1'b1;
                    end else begin
                        arm     = 1'b1;
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                if (regionEnd || !enable)  state_d = IDLE;
                else if (counter > deadline) state_d = EXPIRED;
            end
            EXPIRED: begin
                if (regionEnd || !enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Window snapshot taken at arm time, held for the whole window.
    always_ff @(posedge clk) begin
        if (rst) begin
            begin_reg   <= '0;
            thr_latched <= '0;
            deadline    <= '0;
        end else if (arm) begin
            begin_reg   <= counter;
            thr_latched <= threshold_reg;
            deadline    <= sum[DATA_WIDTH-1:0];
        end
    end

    // Taken counter and overflow flag; a software clear beats any set.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_count     <= '0;
            overflow_sticky <= 1'b0;
        end else if (wr_clr) begin
            taken_count     <= '0;
            overflow_sticky <= 1'b0;
        end else begin
            if (take_inc) taken_count     <= taken_count + TAKEN_CNT_WIDTH'(1);
            if (ovf_set)  overflow_sticky <= 1'b1;
        end
    end

    // CSR readback mux.
    always_comb begin
        csrRData = '0;
        unique case (csrAddr)
            2'd0: csrRData = threshold_reg;
            2'd1: begin
                csrRData[0]   = enable;
                csrRData[2:1] = state_q;
            end
            2'd2: csrRData = begin_reg;
            2'd3: begin
                csrRData[DATA_WIDTH-1]        = overflow_sticky;
                csrRData[TAKEN_CNT_WIDTH-1:0] = taken_count;
            end
            default: csrRData = '0;
        endcase
    end

    assign cyclecounter  = counter;
    assign begincycle    = (state_q == IDLE) ? '0 : begin_reg;
    assign threshold     = (state_q == IDLE) ? '1 : thr_latched;
    assign windowActive  = (state_q != IDLE);
    assign windowExpired = (state_q == EXPIRED);

endmodule
